// File: rtl/simple_risc_pkg.sv
// Shared op codes and FSM state encoding for the SimpleRISC multiply/divide unit.
package simple_risc_pkg;

  localparam logic [1:0] MD_OP_MUL  = 2'b00;
  localparam logic [1:0] MD_OP_DIV  = 2'b01;
  localparam logic [1:0] MD_OP_MOD  = 2'b10;
  localparam logic [1:0] MD_OP_RSVD = 2'b11;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

endpackage

// File: rtl/muldiv_datapath.sv
// Shift-add multiplier / restoring divider. One iteration per i_step; o_result is the
// signed-fixed result as it stands after the current cycle's step.
module muldiv_datapath
  import simple_risc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result
);

  // r_acc: product (MUL) or partial remainder (DIV/MOD); one spare bit for the trial subtract.
  // r_x:   multiplicand (MUL) or dividend-shifting-into-quotient (DIV/MOD).
  // r_y:   multiplier (MUL) or divisor magnitude (DIV/MOD).
  logic [WIDTH:0]   r_acc;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [1:0]       r_op;
  logic             r_neg_q;
  logic             r_neg_r;

  logic [WIDTH:0]   w_acc_nxt;
  logic [WIDTH-1:0] w_x_nxt;
  logic [WIDTH-1:0] w_y_nxt;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_diff;

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_acc_nxt = r_acc;
    w_x_nxt   = r_x;
    w_y_nxt   = r_y;
    w_rem_sh  = '0;
    w_diff    = '0;
    o_result  = '0;
    if (r_op == MD_OP_MUL) begin
      w_acc_nxt = {1'b0, r_acc[WIDTH-1:0] + (r_y[0] ? r_x : '0)};
      w_x_nxt   = r_x << 1;
      w_y_nxt   = r_y >> 1;
      o_result  = w_acc_nxt[WIDTH-1:0];
    end else begin
      // A borrow out of the trial subtract (MSB set) means the divisor did not fit.
      w_rem_sh = {r_acc[WIDTH-1:0], r_x[WIDTH-1]};
      w_diff   = w_rem_sh - {1'b0, r_y};
      if (w_diff[WIDTH]) begin
        w_acc_nxt = w_rem_sh;
        w_x_nxt   = {r_x[WIDTH-2:0], 1'b0};
      end else begin
        w_acc_nxt = w_diff;
        w_x_nxt   = {r_x[WIDTH-2:0], 1'b1};
      end
      if (r_op == MD_OP_DIV)
        o_result = r_neg_q ? (~w_x_nxt + 1'b1) : w_x_nxt;
      else
        o_result = r_neg_r ? (~w_acc_nxt[WIDTH-1:0] + 1'b1) : w_acc_nxt[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_op    <= MD_OP_MUL;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (i_load) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      r_op    <= i_op;
      r_acc   <= '0;
      r_x     <= (i_op == MD_OP_MUL) ? i_a : abs_val(i_a);
      r_y     <= (i_op == MD_OP_MUL) ? i_b : abs_val(i_b);
      r_neg_q <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
      r_neg_r <= i_a[WIDTH-1];
    end else if (i_step) begin
      r_acc <= w_acc_nxt;
      r_x   <= w_x_nxt;
      r_y   <= w_y_nxt;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// FSM, iteration counter, pipeline stall handshake and result/flag registers for the
// multi-cycle MUL/DIV/MOD ops.
module muldiv_sequencer
  import simple_risc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             dbz_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

  md_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_dbz;
  logic             r_done;

  logic             w_accept;
  logic             w_div_zero;
  logic             w_load;
  logic             w_step;
  logic [WIDTH-1:0] w_dp_result;

  assign w_accept   = (r_state == MD_IDLE) && start_i && !flush_i && (op_i != MD_OP_RSVD);
  assign w_div_zero = (op_i != MD_OP_MUL) && (b_i == '0);
  assign w_load     = w_accept && !w_div_zero;
  assign w_step     = (r_state == MD_RUN);

  muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_op     (op_i),
    .i_a      (a_i),
    .i_b      (b_i),
    .o_result (w_dp_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= MD_IDLE;
      r_cnt    <= '0;
      r_result <= '0;
      r_dbz    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        MD_IDLE: begin
          if (w_accept && w_div_zero) begin
            r_state  <= MD_DONE;
            r_result <= (op_i == MD_OP_DIV) ? '1 : a_i;
            r_dbz    <= 1'b1;
            r_done   <= 1'b1;
          end else if (w_accept) begin
            r_state <= MD_RUN;
            r_cnt   <= CNT_INIT;
          end
        end
        MD_RUN: begin
          if (flush_i) begin
            r_state <= MD_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
            // Last iteration: capture the datapath result including this cycle's step.
            if (r_cnt == CNT_W'(1)) begin
              r_state  <= MD_DONE;
              r_result <= w_dp_result;
              r_dbz    <= 1'b0;
              r_done   <= 1'b1;
            end
          end
        end
        MD_DONE: r_state <= MD_IDLE;
        default: r_state <= MD_IDLE;
      endcase
    end
  end

  assign stall_o  = w_accept || (r_state == MD_RUN);
  assign busy_o   = (r_state != MD_IDLE);
  assign done_o   = r_done;
  assign result_o = r_result;
  assign dbz_o    = r_dbz;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: expected results are queued at issue and
// compared when done_o pulses; latency, stall, flush and reset behaviour checked per task.
module tb_muldiv_sequencer;
  import simple_risc_pkg::*;

  localparam int W = 32;
  localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_i = 1'b0;
  logic [1:0]   op_i = 2'b00;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         flush_i = 1'b0;
  logic         stall_o, busy_o, done_o, dbz_o;
  logic [W-1:0] result_o;

  typedef struct packed {
    logic [W-1:0] res;
    logic         dbz;
  } exp_t;

  exp_t         sb[$];
  int           n_checks = 0;
  int           n_fail = 0;
  logic [W-1:0] last_res = '0;
  logic         last_dbz = 1'b0;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .flush_i  (flush_i),
    .stall_o  (stall_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o),
    .dbz_o    (dbz_o)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t e;
    e.dbz = 1'b0;
    e.res = '0;
    if (op == MD_OP_MUL) begin
      e.res = a * b;
    end else if (b == '0) begin
      e.dbz = 1'b1;
      e.res = (op == MD_OP_DIV) ? '1 : a;
    end else if (a == MIN_V && b == '1) begin
      e.res = (op == MD_OP_DIV) ? MIN_V : '0;
    end else if (op == MD_OP_DIV) begin
      e.res = $signed(a) / $signed(b);
    end else begin
      e.res = $signed(a) % $signed(b);
    end
    return e;
  endfunction

  task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input string name);
    exp_t e, got;
    int   lat, exp_lat, stall_cnt;
    bit   seen;
    sb.push_back(model(op, a, b));
    exp_lat = (op != MD_OP_MUL && b == '0) ? 1 : W + 1;
    @(negedge clk);
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    #1;
    n_checks++;
    if (stall_o !== 1'b1) begin
      n_fail++; $display("FAIL %s stall_c0: got %b want 1", name, stall_o);
    end
    @(posedge clk); #1 start_i = 1'b0;
    seen = 0; stall_cnt = 1; lat = 0; got = '0;
    for (int c = 1; c <= W + 10 && !seen; c++) begin
      @(negedge clk);
      if (stall_o) stall_cnt++;
      if (done_o) begin
        seen = 1; lat = c; got.res = result_o; got.dbz = dbz_o;
      end
    end
    n_checks++;
    if (!seen) begin
      n_fail++; $display("FAIL %s timeout: no done_o within %0d cycles", name, W + 10);
      void'(sb.pop_front());
      return;
    end
    if (lat != exp_lat) begin
      n_fail++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    end
    n_checks++;
    if (stall_cnt != exp_lat) begin
      n_fail++; $display("FAIL %s stall_cycles: got %0d want %0d", name, stall_cnt, exp_lat);
    end
    e = sb.pop_front();
    n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL %s result: got %h dbz %b want %h dbz %b", name, got.res, got.dbz, e.res, e.dbz);
    end
    last_res = e.res; last_dbz = e.dbz;
    @(negedge clk);
    n_checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || result_o !== e.res) begin
      n_fail++;
      $display("FAIL %s after_done: done %b busy %b res %h want 0 0 %h", name, done_o, busy_o,
               result_o, e.res);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({stall_o, busy_o, done_o, dbz_o} !== 4'b0 || result_o !== '0) begin
      n_fail++;
      $display("FAIL reset_state: stall %b busy %b done %b dbz %b res %h want all 0",
               stall_o, busy_o, done_o, dbz_o, result_o);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_mul();
    do_op(MD_OP_MUL, 32'd7, 32'd6, "mul_7x6");
    do_op(MD_OP_MUL, 32'hFFFF_FFFD, 32'd5, "mul_neg3x5");
  endtask

  task automatic test_divmod();
    do_op(MD_OP_DIV, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    do_op(MD_OP_MOD, 32'hFFFF_FFF9, 32'd2, "mod_m7_2");
    do_op(MD_OP_MOD, 32'd7, 32'hFFFF_FFFE, "mod_7_m2");
  endtask

  task automatic test_div_zero();
    do_op(MD_OP_DIV, 32'd5, 32'd0, "div_5_0");
    do_op(MD_OP_MOD, 32'd5, 32'd0, "mod_5_0");
  endtask

  task automatic test_flush();
    int dones;
    @(negedge clk);
    start_i = 1'b1; op_i = MD_OP_MUL; a_i = 32'd5; b_i = 32'd5;
    @(posedge clk); #1 start_i = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 10) flush_i = 1'b1;
    end
    @(posedge clk); #1 flush_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b0 || stall_o !== 1'b0) begin
      n_fail++; $display("FAIL flush_idle: busy %b stall %b want 0 0", busy_o, stall_o);
    end
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done_o) dones++;
    end
    n_checks++;
    if (dones != 0 || result_o !== last_res || dbz_o !== last_dbz) begin
      n_fail++;
      $display("FAIL flush_hold: dones %0d res %h dbz %b want 0 %h %b", dones, result_o, dbz_o,
               last_res, last_dbz);
    end
  endtask

  task automatic test_ignored_starts();
    int dones;
    // Reserved op: no stall, no busy, no done.
    @(negedge clk);
    start_i = 1'b1; op_i = MD_OP_RSVD; a_i = 32'd1; b_i = 32'd1;
    #1;
    n_checks++;
    if (stall_o !== 1'b0) begin
      n_fail++; $display("FAIL rsvd_stall: got %b want 0", stall_o);
    end
    @(posedge clk); #1 start_i = 1'b0;
    // Flush together with start in IDLE: flush wins.
    @(negedge clk);
    start_i = 1'b1; flush_i = 1'b1; op_i = MD_OP_MUL;
    #1;
    n_checks++;
    if (stall_o !== 1'b0) begin
      n_fail++; $display("FAIL flush_start_stall: got %b want 0", stall_o);
    end
    @(posedge clk); #1 start_i = 1'b0; flush_i = 1'b0;
    dones = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done_o || busy_o) dones++;
    end
    n_checks++;
    if (dones != 0) begin
      n_fail++; $display("FAIL ignored_busy: busy/done cycles %0d want 0", dones);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e, got;
    int   dones, lat;
    sb.push_back(model(MD_OP_DIV, MIN_V, '1));
    @(negedge clk);
    start_i = 1'b1; op_i = MD_OP_DIV; a_i = MIN_V; b_i = '1;
    @(posedge clk); #1 start_i = 1'b0;
    dones = 0; lat = 0; got = '0;
    for (int c = 1; c <= W + 20; c++) begin
      @(negedge clk);
      if (c == 5) begin
        start_i = 1'b1; op_i = MD_OP_MUL; a_i = 32'd3; b_i = 32'd3;
      end
      if (c == 6) start_i = 1'b0;
      if (done_o) begin
        dones++;
        if (dones == 1) begin
          lat = c; got.res = result_o; got.dbz = dbz_o;
        end
      end
    end
    n_checks++;
    if (dones != 1 || lat != W + 1) begin
      n_fail++; $display("FAIL b2b_done: count %0d lat %0d want 1 %0d", dones, lat, W + 1);
    end
    e = sb.pop_front();
    n_checks++;
    if (got !== e) begin
      n_fail++; $display("FAIL b2b_result: got %h dbz %b want %h dbz %b", got.res, got.dbz,
                         e.res, e.dbz);
    end
    last_res = e.res; last_dbz = e.dbz;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    start_i = 1'b1; op_i = MD_OP_MUL; a_i = 32'd9; b_i = 32'd9;
    @(posedge clk); #1 start_i = 1'b0;
    for (int c = 1; c <= 15; c++) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({stall_o, busy_o, done_o, dbz_o} !== 4'b0 || result_o !== '0) begin
      n_fail++;
      $display("FAIL async_reset: stall %b busy %b done %b dbz %b res %h want all 0",
               stall_o, busy_o, done_o, dbz_o, result_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_res = '0; last_dbz = 1'b0;
    do_op(MD_OP_MUL, 32'd3, 32'd3, "mul_after_reset");
  endtask

  task automatic test_random();
    logic [1:0]   op;
    logic [W-1:0] a, b;
    for (int i = 0; i < 8; i++) begin
      op = 2'($urandom_range(0, 2));
      a  = $urandom;
      b  = (i % 2 == 0) ? W'($urandom_range(1, 100)) : $urandom;
      if ($urandom_range(0, 1) == 1) b = ~b + 1'b1;
      do_op(op, a, b, "random");
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_divmod();
    test_div_zero();
    test_flush();
    test_ignored_starts();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
